// File: rtl/systolic_pkg.sv
// Shared types for the systolic array: feeder state encoding and accumulator width helper.
// Combinational definitions only; no latency or backpressure of its own.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } feed_state_t;

   function automatic int ACC_W(input int datawidth, input int columns);
      return 2 * datawidth + $clog2(columns);
   endfunction

endpackage

// File: rtl/act_skew_feeder_if.sv
// Activation vector handshake into the feeder: valid/ready with a last-of-batch qualifier.
// Transfer happens on a rising edge where in_valid and in_ready are both high.
interface act_skew_feeder_if #(
   parameter int columns   = 64,
   parameter int datawidth = 11
);
   logic                          in_valid;
   logic                          in_ready;
   logic                          in_last;
   logic [columns*datawidth-1:0]  in_vec;

   modport master (
      output in_valid,
      output in_last,
      output in_vec,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_last,
      input  in_vec,
      output in_ready
   );
endinterface

// File: rtl/act_skew_feeder_skew_line.sv
// Fixed-depth shift register with synchronous clear; latency = depth cycles, no backpressure.
// Stage 0 captures i_d every cycle, o_q is the last stage.
module skew_line #(
   parameter int depth = 1,
   parameter int width = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [width-1:0] i_d,
   output logic [width-1:0] o_q
);

   logic [width-1:0] r_stage [depth];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < depth; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < depth; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[depth-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Skews activation vectors into the systolic array (column c delayed c cycles) and tags results.
// One vector per cycle while streaming; in_ready drops in DRAIN/DONE, under train_en and reset.
module act_skew_feeder
   import systolic_pkg::*;
#(
   parameter int columns   = 64,
   parameter int datawidth = 11
) (
   input  logic                          clk,
   input  logic                          rst_overall,
   input  logic                          train_en,
   act_skew_feeder_if.slave              s_in,
   output logic [columns*datawidth-1:0]  value_out,
   output logic                          res_valid,
   output logic                          res_last,
   output logic                          busy,
   output logic                          done
);

   localparam int CNT_W = $clog2(columns);

   feed_state_t      r_state;
   feed_state_t      w_state_nxt;
   logic [CNT_W-1:0] r_drain_cnt;
   logic             w_accept;
   logic [1:0]       w_tag;

   assign s_in.in_ready = ((r_state == IDLE) || (r_state == STREAM)) && !train_en && !rst_overall;
   assign w_accept      = s_in.in_valid && s_in.in_ready;

   always_ff @(posedge clk) begin
      if (rst_overall) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = s_in.in_last ? DRAIN : STREAM;
            end
         end
         STREAM: begin
            if (w_accept && s_in.in_last) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (r_drain_cnt == CNT_W'(columns - 1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Held at zero outside DRAIN, so it is always clear on entry.
   always_ff @(posedge clk) begin
      if (rst_overall) begin
         r_drain_cnt <= '0;
      end else if (r_state == DRAIN) begin
         r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
         r_drain_cnt <= '0;
      end
   end

   for (genvar c = 0; c < columns; c++) begin : g_col
      logic [datawidth-1:0] w_elem;

      assign w_elem = w_accept ? s_in.in_vec[c*datawidth +: datawidth] : '0;

      skew_line #(
         .depth (c + 1),
         .width (datawidth)
      ) u_line (
         .i_clk (clk),
         .i_rst (rst_overall),
         .i_d   (w_elem),
         .o_q   (value_out[c*datawidth +: datawidth])
      );
   end

   // One stage beyond the deepest column: the east-most PE captures on the edge after
   // its column value appears, so the tag must trail that column by one cycle.
   skew_line #(
      .depth (columns + 1),
      .width (2)
   ) u_tag (
      .i_clk (clk),
      .i_rst (rst_overall),
      .i_d   ({w_accept, w_accept && s_in.in_last}),
      .o_q   (w_tag)
   );

   assign res_valid = w_tag[1];
   assign res_last  = w_tag[0];
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

endmodule
